// File: rtl/dac_sched_pkg.sv
// Shared types for the DAC sample scheduler: output-state encoding and the
// excess-2**MSBI midscale code.
package dac_sched_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    RAMP_DOWN = 2'd1,
    MUTED     = 2'd2,
    RAMP_UP   = 2'd3
  } sched_state_e;

  function automatic int unsigned midscale(input int unsigned msbi);
    return 32'd1 << msbi;
  endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Synchronous show-ahead FIFO: rd_data always presents the oldest entry.
// Writes when full and reads when empty are ignored.
module dac_sample_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr, do_rd;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rd_data  = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/dac_sample_sched.sv
// Sample scheduler for the sigma-delta DAC: CEN divider, OSR sample ticks,
// PCM FIFO, underflow flag and mute. DAC_SOFT_MUTE_EN enables the ramped mute.
module dac_sample_sched #(
  parameter int MSBI       = 7,
  parameter int CEN_DIV    = 4,
  parameter int OSR        = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int RAMP_STEP  = 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [MSBI:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          mute,
  input  logic          underflow_clr,
  output logic [MSBI:0] dac_data,
  output logic          dac_cen,
  output logic          sample_strobe,
  output logic          underflow
);

  import dac_sched_pkg::*;

  localparam int DW = MSBI + 1;
  localparam int CW = (CEN_DIV > 1) ? $clog2(CEN_DIV) : 1;
  localparam int OW = $clog2(OSR);
  localparam logic [CW-1:0] CEN_LAST = CW'(CEN_DIV - 1);
  localparam logic [OW-1:0] OSR_LAST = OW'(OSR - 1);
  localparam logic [DW-1:0] MID      = DW'(midscale(MSBI));
  // Steps at least as large as the code range just mean "snap immediately".
  localparam logic [DW-1:0] STEP     = (RAMP_STEP >= (1 << DW)) ? '1 : DW'(RAMP_STEP);

  logic [CW-1:0] cen_cnt_q, cen_cnt_d;
  logic          dac_cen_q, dac_cen_d;
  logic [OW-1:0] osr_cnt_q, osr_cnt_d;
  logic          sample_strobe_q, sample_strobe_d;
  logic          underflow_q, underflow_d;
  logic [DW-1:0] cur_sample_q, cur_sample_d;
  logic [DW-1:0] dac_data_q, dac_data_d;
  sched_state_e  state_q, state_d;
  logic          tick;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DW-1:0] fifo_rd_data;

  // Moves one ramp step from 'from' toward 'to', landing exactly on 'to' when close.
  function automatic logic [DW-1:0] step_toward(input logic [DW-1:0] from,
                                                input logic [DW-1:0] to);
    logic signed [DW:0] diff;
    diff = $signed({1'b0, to}) - $signed({1'b0, from});
    if (diff > $signed({1'b0, STEP}))       return from + STEP;
    else if (diff < -$signed({1'b0, STEP})) return from - STEP;
    else                                    return to;
  endfunction

  dac_sample_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RESET),
    .wr_en   (fifo_push),
    .wr_data (in_data),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // dac_cen is registered from the next count so it is low during reset even when CEN_DIV=1.
  always_comb begin
    cen_cnt_d       = (cen_cnt_q == CEN_LAST) ? '0 : cen_cnt_q + 1'b1;
    dac_cen_d       = (cen_cnt_d == CEN_LAST);
    osr_cnt_d       = osr_cnt_q;
    if (dac_cen_q) osr_cnt_d = (osr_cnt_q == OSR_LAST) ? '0 : osr_cnt_q + 1'b1;
    tick            = dac_cen_q && (osr_cnt_q == OSR_LAST);
    sample_strobe_d = tick;
    fifo_push       = in_valid && !fifo_full;
    fifo_pop        = tick && !fifo_empty;
    cur_sample_d    = fifo_pop ? fifo_rd_data : cur_sample_q;
    underflow_d     = underflow_q;
    if (tick && fifo_empty) underflow_d = 1'b1;
    else if (underflow_clr) underflow_d = 1'b0;
  end

`ifdef DAC_SOFT_MUTE_EN
  always_comb begin
    sched_state_e eff;
    eff        = state_q;
    state_d    = state_q;
    dac_data_d = dac_data_q;
    if (tick) begin
      // A mute change takes effect on the very tick that observes it.
      case (state_q)
        RUN:     eff = mute ? RAMP_DOWN : RUN;
        MUTED:   eff = mute ? MUTED : RAMP_UP;
        default: eff = mute ? RAMP_DOWN : RAMP_UP;
      endcase
      case (eff)
        RUN: begin
          dac_data_d = cur_sample_d;
          state_d    = RUN;
        end
        RAMP_DOWN: begin
          dac_data_d = step_toward(dac_data_q, MID);
          state_d    = (dac_data_d == MID) ? MUTED : RAMP_DOWN;
        end
        RAMP_UP: begin
          dac_data_d = step_toward(dac_data_q, cur_sample_d);
          state_d    = (dac_data_d == cur_sample_d) ? RUN : RAMP_UP;
        end
        default: begin
          dac_data_d = MID;
          state_d    = MUTED;
        end
      endcase
    end
  end
`else
  always_comb begin
    state_d    = state_q;
    dac_data_d = dac_data_q;
    if (tick) begin
      state_d    = mute ? MUTED : RUN;
      dac_data_d = mute ? MID : cur_sample_d;
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments; RESET is asynchronous, so it sits in the sensitivity list.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cen_cnt_q       <= '0;
      dac_cen_q       <= 1'b0;
      osr_cnt_q       <= '0;
      sample_strobe_q <= 1'b0;
      underflow_q     <= 1'b0;
      cur_sample_q    <= MID;
      dac_data_q      <= MID;
      state_q         <= RUN;
    end else begin
      cen_cnt_q       <= cen_cnt_d;
      dac_cen_q       <= dac_cen_d;
      osr_cnt_q       <= osr_cnt_d;
      sample_strobe_q <= sample_strobe_d;
      underflow_q     <= underflow_d;
      cur_sample_q    <= cur_sample_d;
      dac_data_q      <= dac_data_d;
      state_q         <= state_d;
    end
  end

  assign in_ready      = !fifo_full;
  assign dac_data      = dac_data_q;
  assign dac_cen       = dac_cen_q;
  assign sample_strobe = sample_strobe_q;
  assign underflow     = underflow_q;

endmodule

// File: tb/tb_dac_sample_sched.sv
// Scoreboard bench for dac_sample_sched with CEN_DIV=4, OSR=4 (16-cycle sample
// period); expected mute behaviour follows DAC_SOFT_MUTE_EN.
module tb_dac_sample_sched;

  typedef struct packed {
    logic [7:0] dac;
    logic       uf;
  } exp_t;

  logic       clk;
  logic       RESET;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       mute;
  logic       underflow_clr;
  logic [7:0] dac_data;
  logic       dac_cen;
  logic       sample_strobe;
  logic       underflow;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  dac_sample_sched #(
    .MSBI       (7),
    .CEN_DIV    (4),
    .OSR        (4),
    .FIFO_DEPTH (4),
    .RAMP_STEP  (16)
  ) dut (
    .CLK           (clk),
    .RESET         (RESET),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .mute          (mute),
    .underflow_clr (underflow_clr),
    .dac_data      (dac_data),
    .dac_cen       (dac_cen),
    .sample_strobe (sample_strobe),
    .underflow     (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_dac_data"}, dac_data, 8'h80);
    check({tag, "_dac_cen"}, dac_cen, 0);
    check({tag, "_strobe"}, sample_strobe, 0);
    check({tag, "_underflow"}, underflow, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  task automatic wait_strobe();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = sample_strobe;
    end
    if (!seen) check("strobe_timeout", 0, 1);
  endtask

  task automatic push_one(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_tick(input logic [7:0] d, input logic uf);
    exp_t e;
    e.dac = d;
    e.uf  = uf;
    exp_q.push_back(e);
  endtask

  // Scoreboard consumer: every strobe pops one expectation; also checks the period.
  initial begin
    int   cyc;
    int   last;
    exp_t e;
    cyc  = 0;
    last = -1;
    forever begin
      @(negedge clk);
      if (RESET) begin
        cyc  = 0;
        last = -1;
      end else begin
        cyc++;
        if (sample_strobe) begin
          if (last >= 0) check("strobe_period", cyc - last, 16);
          last = cyc;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("dac_data", dac_data, e.dac);
            check("underflow", underflow, e.uf);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_cen;
    int n_strobe;
    int first_cen;
    n_cen     = 0;
    n_strobe  = 0;
    first_cen = -1;

    RESET = 1'b1; in_valid = 1'b0; in_data = '0; mute = 1'b0; underflow_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("por");

    // Stream three samples well ahead of the first tick.
    expect_tick(8'h10, 1'b0);
    expect_tick(8'h20, 1'b0);
    expect_tick(8'h30, 1'b0);
    expect_tick(8'h30, 1'b1);
    RESET = 1'b0;
    fork
      begin
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
          in_data = 8'(16 * (i + 1));
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin
        for (int i = 1; i <= 32; i++) begin
          @(negedge clk);
          if (dac_cen) begin
            n_cen++;
            if (first_cen < 0) first_cen = i;
          end
          if (sample_strobe) n_strobe++;
        end
      end
    join
    check("cen_count", n_cen, 8);
    check("cen_first", first_cen, 3);
    check("strobe_count", n_strobe, 2);
    wait_strobe();
    wait_strobe();

    // Underflow clear, then a clear coincident with a fresh underflow.
    underflow_clr = 1'b1;
    @(negedge clk);
    underflow_clr = 1'b0;
    check("uf_cleared", underflow, 0);
    repeat (14) @(negedge clk);
    check("tick_cycle_cen", dac_cen, 1);
    underflow_clr = 1'b1;
    expect_tick(8'h30, 1'b1);
    @(negedge clk);
    underflow_clr = 1'b0;
    check("strobe_on_tick", sample_strobe, 1);
    check("uf_set_wins", underflow, 1);

    // Fill the FIFO between ticks, keep in_valid high against backpressure.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'h41 + i);
      @(negedge clk);
    end
    in_data = 8'h45;
    check("full_not_ready", in_ready, 0);
    expect_tick(8'h41, 1'b1);
    repeat (11) @(negedge clk);
    check("held_full", in_ready, 0);
    @(negedge clk);
    check("ready_after_pop", in_ready, 1);
    @(negedge clk);
    check("refull", in_ready, 0);
    in_valid = 1'b0;
    underflow_clr = 1'b1;
    @(negedge clk);
    underflow_clr = 1'b0;
    check("uf_cleared2", underflow, 0);
    repeat (4) @(negedge clk);

    // Mid-period reset with a full FIFO: immediate reset values, FIFO flushed.
    RESET = 1'b1;
    #1;
    check_reset_state("mid");
    repeat (2) @(negedge clk);
    RESET = 1'b0;
    push_one(8'hC0);
    expect_tick(8'hC0, 1'b0);
    wait_strobe();
    mute = 1'b1;

`ifdef DAC_SOFT_MUTE_EN
    expect_tick(8'hB0, 1'b1);
    expect_tick(8'hA0, 1'b1);
    expect_tick(8'h90, 1'b1);
    expect_tick(8'h80, 1'b1);
    expect_tick(8'h80, 1'b1);
    repeat (5) wait_strobe();
    mute = 1'b0;
    underflow_clr = 1'b1;
    push_one(8'hA0);
    underflow_clr = 1'b0;
    expect_tick(8'h90, 1'b0);
    expect_tick(8'hA0, 1'b1);
    repeat (2) wait_strobe();
    push_one(8'h55);
    expect_tick(8'h55, 1'b1);
    wait_strobe();
`else
    expect_tick(8'h80, 1'b1);
    expect_tick(8'h80, 1'b1);
    repeat (2) wait_strobe();
    mute = 1'b0;
    push_one(8'h33);
    expect_tick(8'h33, 1'b1);
    wait_strobe();
`endif

    repeat (2) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dac_sample_sched.md
# dac_sample_sched

Sample scheduler and controller for the sigma-delta DAC. Generates the DAC clock-enable (oversampling tick), buffers PCM samples from the audio producer in a small FIFO, presents one sample per sample period on the DAC input, and handles underflow and mute with an optional soft ramp to midscale. It sits between the audio source and the `sigma_delta_dac` instance and drives that instance's `DACin` and `CEN`.

## Interface
- `MSBI`, 7: sample MSB index; samples are `MSBI+1` bits, excess-2**MSBI (midscale = 1<<MSBI).
- `CEN_DIV`, 4: CLK cycles per `dac_cen` pulse; ≥1.
- `OSR`, 64: `dac_cen` pulses per sample period; ≥2.
- `FIFO_DEPTH`, 4: sample FIFO depth; power of 2, ≥2.
- `RAMP_STEP`, 1: magnitude change per sample period during soft ramp; ≥1.

- `CLK` in 1: single clock.
- `RESET` in 1: asynchronous, active-high reset.
- `in_data` in MSBI+1: sample from producer.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: FIFO can accept; push on `in_valid && in_ready`.
- `mute` in 1: level; request output at midscale.
- `underflow_clr` in 1: clears `underflow`.
- `dac_data` out MSBI+1: to DAC `DACin`.
- `dac_cen` out 1: to DAC `CEN`.
- `sample_strobe` out 1: one-cycle pulse on each sample tick.
- `underflow` out 1: sticky; sample tick found FIFO empty.

## Operation
- Reset values: `dac_data`=1<<MSBI, `dac_cen`=0, `sample_strobe`=0, `underflow`=0, `in_ready`=1 (FIFO empty), state RUN, counters 0.
- CEN divider: counter 0..CEN_DIV-1; `dac_cen`=1 in cycle where counter==CEN_DIV-1. CEN_DIV=1 → `dac_cen` high every cycle after reset.
- OSR counter: advances on `dac_cen`, wraps at OSR-1. Sample tick = `dac_cen` && osr counter==OSR-1; `sample_strobe` is registered copy (high the cycle after tick).
- FIFO: `in_ready` = !full. On sample tick, if non-empty pop into `cur_sample`; if empty set `underflow`, `cur_sample` holds. Push and pop same cycle allowed when neither full nor empty; a push into an empty FIFO in the tick cycle is not visible to that tick (no bypass → underflow).
- `underflow`: set and `underflow_clr` in same cycle → set wins.
- State machine (evaluated on sample ticks only, `dac_data` updated on the same edge):
  - RUN: `dac_data`←popped sample. `mute`=1 → RAMP_DOWN.
  - RAMP_DOWN: `dac_data` moves RAMP_STEP toward midscale; within RAMP_STEP → snap to midscale, MUTED. `mute`=0 → RAMP_UP.
  - MUTED: `dac_data`=midscale; FIFO still drained. `mute`=0 → RAMP_UP.
  - RAMP_UP: target = `cur_sample`; step toward it by RAMP_STEP; within RAMP_STEP → snap, RUN. `mute`=1 → RAMP_DOWN.
- Arithmetic: ramp done in MSBI+2-bit signed difference; no overflow, no wrap past target or midscale.

## Timing
- `dac_data` changes only on the edge ending a sample-tick cycle; the DAC sees it at its next `dac_cen`, CEN_DIV cycles later.
- Push-to-visible: sample pushed at edge N is poppable by a tick at cycle ≥N+1.
- Sample period = CEN_DIV×OSR CLK cycles, exact, independent of FIFO state.
- `RESET` mid-ramp or mid-period: immediate return to reset values, FIFO flushed.

## Configuration
- `DAC_SOFT_MUTE_EN` defined: four-state ramp machine above.
- Undefined: only RUN/MUTED; `mute`=1 forces `dac_data` to midscale at the next sample tick, `mute`=0 resumes popped samples at the next tick; RAMP_STEP ignored.

## Structure
- Package `dac_sched_pkg`: state enum (RUN, RAMP_DOWN, MUTED, RAMP_UP), midscale function of MSBI.
- Sub-module `dac_sample_fifo`: synchronous FIFO with full/empty, parameterised width/depth.

## Test plan
- Reset: CEN_DIV=4, OSR=4 → `dac_cen` every 4th cycle, `sample_strobe` every 16 cycles, `dac_data`=0x80.
- Stream 0x10,0x20,0x30 ahead of ticks → `dac_data` steps 0x10→0x20→0x30 one per 16 cycles; `underflow` stays 0.
- Empty FIFO at tick after 0x30 → `dac_data` holds 0x30, `underflow`=1; pulse `underflow_clr` → 0; clr coincident with new underflow → stays 1.
- Fill 4 samples without ticks → `in_ready`=0; `in_valid` held high → no push until next pop, then `in_ready`=1.
- Soft mute (macro on, RAMP_STEP=16) from 0xC0 → 0xB0,0xA0,0x90,0x80 then MUTED; unmute with FIFO 0xA0 → 0x90,0xA0, RUN.
- Macro off: `mute` at 0xC0 → 0x80 at next tick; release → next popped sample directly.
